// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive byte buffer between the UART receiver and the host. Bytes
//   strobed by the receiver are stored in a DEPTH-entry FIFO and presented
//   first-word-fall-through on a valid/ready interface. Overrun and framing
//   errors are reported as sticky flags. afull is intended for RTS-style
//   flow control toward the line side.
//
//   Optional feature macro: UART_RX_FIFO_STATS_EN
//     defined   : drop_cnt counts dropped bytes and saturates at 16'hFFFF
//     undefined : drop_cnt is tied to zero
//
// Ports
//   Clk, Rst_n        system clock, synchronous active-low reset
//   rx_data/valid/ferr byte strobe from the UART receiver
//   flush             clears FIFO contents, leaves the error flags alone
//   m_data/valid/ready FWFT output toward the host
//   count/full/afull  occupancy status
//   overrun/ferr      sticky error flags, cleared by err_clr
//   drop_cnt          dropped-byte counter
module uart_rx_fifo #(
   parameter int DATA_W       = 8,
   parameter int DEPTH        = 16,
   parameter int AFULL_THRESH = 12
) (
   input  logic                       Clk,
   input  logic                       Rst_n,
   input  logic [DATA_W-1:0]          rx_data,
   input  logic                       rx_valid,
   input  logic                       rx_ferr,
   input  logic                       flush,
   output logic [DATA_W-1:0]          m_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       afull,
   output logic                       overrun,
   output logic                       ferr,
   input  logic                       err_clr,
   output logic [15:0]                drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;

   logic push_req;
   logic pop;
   logic push;
   logic drop_ovr;
   logic drop_fe;
   logic drop;

   assign m_valid  = (count != '0);
   assign full     = (count == CW'(DEPTH));
   assign afull    = (count >= CW'(AFULL_THRESH));
   // Gate the read so the output sits at zero while empty (storage itself
   // is never reset).
   assign m_data   = m_valid ? mem[rd_ptr] : '0;

   assign push_req = rx_valid & ~rx_ferr;
   assign pop      = m_valid & m_ready;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign push     = push_req & (~full | pop);
   assign drop_ovr = push_req & full & ~pop;
   assign drop_fe  = rx_valid & rx_ferr;
   assign drop     = drop_ovr | drop_fe;

   always_ff @(posedge Clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= rx_data;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // A new error event wins over err_clr in the same cycle.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         overrun <= 1'b0;
         ferr    <= 1'b0;
      end else begin
         overrun <= (overrun & ~err_clr) | drop_ovr;
         ferr    <= (ferr & ~err_clr) | drop_fe;
      end
   end

`ifdef UART_RX_FIFO_STATS_EN
   logic [15:0] drop_cnt_q;

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         drop_cnt_q <= '0;
      end else if (err_clr) begin
         drop_cnt_q <= drop ? 16'd1 : 16'd0;
      end else if (drop && drop_cnt_q != 16'hFFFF) begin
         drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   logic unused_drop;
   assign unused_drop = drop;
   assign drop_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ferr;
   logic        flush;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic [4:0]  count;
   logic        full;
   logic        afull;
   logic        overrun;
   logic        ferr;
   logic        err_clr;
   logic [15:0] drop_cnt;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]  exp_q[$];
   logic        m_ovr;
   logic        m_fe;
   logic [15:0] m_drop;

   uart_rx_fifo #(.DATA_W(8), .DEPTH(16), .AFULL_THRESH(12)) dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ferr  (rx_ferr),
      .flush    (flush),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .count    (count),
      .full     (full),
      .afull    (afull),
      .overrun  (overrun),
      .ferr     (ferr),
      .err_clr  (err_clr),
      .drop_cnt (drop_cnt)
   );

   always #5 Clk = ~Clk;

   function automatic logic [15:0] exp_drop();
`ifdef UART_RX_FIFO_STATS_EN
      return m_drop;
`else
      return 16'h0000;
`endif
   endfunction

   task automatic idle_inputs();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      rx_ferr  = 1'b0;
      flush    = 1'b0;
      m_ready  = 1'b0;
      err_clr  = 1'b0;
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_ovr  = 1'b0;
      m_fe   = 1'b0;
      m_drop = 16'h0;
   endtask

   // One clock of stimulus: scoreboard pops are compared before the edge,
   // model is advanced, and the registered status is compared after it.
   task automatic step(input logic v, input logic [7:0] d, input logic fe,
                       input logic rdy, input logic fl, input logic ec);
      logic mpop, mpush, dovr, dfe;
      logic [7:0] head;
      rx_valid = v;
      rx_data  = d;
      rx_ferr  = fe;
      m_ready  = rdy;
      flush    = fl;
      err_clr  = ec;
      mpop  = (exp_q.size() != 0) && rdy;
      mpush = v && !fe && ((exp_q.size() < 16) || mpop);
      dovr  = v && !fe && (exp_q.size() == 16) && !mpop;
      dfe   = v && fe;
      if (mpop) begin
         head = exp_q[0];
         n_cmp++;
         if (m_data !== head) begin
            n_err++;
            $display("FAIL pop_data: got %h expected %h", m_data, head);
         end
      end
      if (fl) begin
         exp_q.delete();
      end else begin
         if (mpop) void'(exp_q.pop_front());
         if (mpush) exp_q.push_back(d);
      end
      m_ovr = (m_ovr && !ec) || dovr;
      m_fe  = (m_fe && !ec) || dfe;
      if (ec) m_drop = (dovr || dfe) ? 16'd1 : 16'd0;
      else if ((dovr || dfe) && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      @(posedge Clk);
      #1;
      idle_inputs();
      n_cmp++;
      if (count !== 5'(exp_q.size())) begin
         n_err++;
         $display("FAIL count: got %0d expected %0d", count, exp_q.size());
      end
      n_cmp++;
      if (m_valid !== (exp_q.size() != 0)) begin
         n_err++;
         $display("FAIL m_valid: got %b expected %b", m_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
         head = exp_q[0];
         n_cmp++;
         if (m_data !== head) begin
            n_err++;
            $display("FAIL head_data: got %h expected %h", m_data, head);
         end
      end
      n_cmp++;
      if (overrun !== m_ovr || ferr !== m_fe) begin
         n_err++;
         $display("FAIL flags: got ovr=%b ferr=%b expected ovr=%b ferr=%b",
                  overrun, ferr, m_ovr, m_fe);
      end
      n_cmp++;
      if (drop_cnt !== exp_drop()) begin
         n_err++;
         $display("FAIL drop_cnt: got %0d expected %0d", drop_cnt, exp_drop());
      end
   endtask

   task automatic apply_reset();
      Rst_n = 1'b0;
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      model_reset();
   endtask

   task automatic check_reset_values(input string tag);
      n_cmp++;
      if (count !== 5'd0 || m_valid !== 1'b0 || m_data !== 8'h00 || full !== 1'b0 ||
          afull !== 1'b0 || overrun !== 1'b0 || ferr !== 1'b0 || drop_cnt !== 16'h0) begin
         n_err++;
         $display("FAIL %s: got cnt=%0d mv=%b md=%h full=%b afull=%b ovr=%b ferr=%b drop=%0d expected all zero",
                  tag, count, m_valid, m_data, full, afull, overrun, ferr, drop_cnt);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      Rst_n = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      model_reset();
      check_reset_values("reset_state");
   endtask

   task automatic test_single();
      step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== 8'h55 || count !== 5'd1) begin
         n_err++;
         $display("FAIL single_fwft: got mv=%b md=%h cnt=%0d expected 1 55 1", m_valid, m_data, count);
      end
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (m_valid !== 1'b0 || count !== 5'd0) begin
         n_err++;
         $display("FAIL single_pop: got mv=%b cnt=%0d expected 0 0", m_valid, count);
      end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
         n_cmp++;
         if (afull !== (i + 1 >= 12) || full !== (i + 1 == 16)) begin
            n_err++;
            $display("FAIL fill_status: n=%0d got afull=%b full=%b expected %b %b",
                     i + 1, afull, full, i + 1 >= 12, i + 1 == 16);
         end
      end
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      n_cmp++;
      if (m_valid !== 1'b0 || full !== 1'b0 || afull !== 1'b0) begin
         n_err++;
         $display("FAIL drained: got mv=%b full=%b afull=%b expected 0 0 0", m_valid, full, afull);
      end
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      end
      step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (overrun !== 1'b1 || count !== 5'd16) begin
         n_err++;
         $display("FAIL overrun_drop: got ovr=%b cnt=%0d expected 1 16", overrun, count);
      end
      step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (count !== 5'd16 || full !== 1'b1) begin
         n_err++;
         $display("FAIL full_push_pop: got cnt=%0d full=%b expected 16 1", count, full);
      end
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (overrun !== 1'b0 || drop_cnt !== 16'h0) begin
         n_err++;
         $display("FAIL overrun_clr: got ovr=%b drop=%0d expected 0 0", overrun, drop_cnt);
      end
   endtask

   task automatic test_ferr();
      step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
`ifdef UART_RX_FIFO_STATS_EN
      if (ferr !== 1'b1 || count !== 5'd1 || drop_cnt !== 16'd1) begin
`else
      if (ferr !== 1'b1 || count !== 5'd1 || drop_cnt !== 16'd0) begin
`endif
         n_err++;
         $display("FAIL ferr_set: got ferr=%b cnt=%0d drop=%0d", ferr, count, drop_cnt);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (ferr !== 1'b0 || drop_cnt !== 16'd0) begin
         n_err++;
         $display("FAIL ferr_clr: got ferr=%b drop=%0d expected 0 0", ferr, drop_cnt);
      end
      // set and clear in the same cycle: the set wins
      step(1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (ferr !== 1'b1) begin
         n_err++;
         $display("FAIL ferr_set_wins: got %b expected 1", ferr);
      end
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_flush_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      end
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      end
      // the last push above overflowed, so overrun must survive the flush
      step(1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (count !== 5'd0 || m_valid !== 1'b0 || overrun !== 1'b1) begin
         n_err++;
         $display("FAIL flush: got cnt=%0d mv=%b ovr=%b expected 0 0 1", count, m_valid, overrun);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      end
      apply_reset();
      check_reset_values("midstream_reset");
   endtask

   task automatic test_wrap();
      int max_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'b0,
              1'($urandom_range(0, 2) != 0), 1'b0, 1'b0);
         if (int'(count) > max_cnt) max_cnt = int'(count);
      end
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      n_cmp++;
      if (max_cnt > 16 || m_valid !== 1'b0) begin
         n_err++;
         $display("FAIL wrap: got max_cnt=%0d mv=%b expected <=16 0", max_cnt, m_valid);
      end
   endtask

   initial begin
      idle_inputs();
      Rst_n = 1'b1;
      model_reset();
      @(posedge Clk);
      #1;
      test_reset();
      test_single();
      test_fill_drain();
      test_overrun();
      test_ferr();
      test_flush_reset();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer directly downstream of the UART receiver. Captures each byte the receiver strobes out, holds up to DEPTH bytes, and presents them to the host side on a first-word-fall-through valid/ready interface. Flags overrun and framing errors as sticky status bits, and drives almost-full for RTS-style flow control back toward the line side.

Parameters:
DATA_W, 8, width of one received character
DEPTH, 16, FIFO entries; power of 2, min 2
AFULL_THRESH, 12, afull asserts when count >= this value; range 1..DEPTH

Ports:
Clk  in  1  system clock; 10 ns period in bench (16 clocks per bit at the bench baud)
Rst_n  in  1  synchronous active-low reset, sampled on rising Clk
rx_data  in  DATA_W  byte from UART receiver
rx_valid  in  1  single-cycle strobe: rx_data/rx_ferr valid this cycle
rx_ferr  in  1  stop bit sampled low for this byte; qualified by rx_valid
flush  in  1  synchronous clear of FIFO contents (not sticky flags)
m_data  out  DATA_W  head-of-FIFO byte
m_valid  out  1  FIFO non-empty; m_data valid
m_ready  in  1  consumer accepts m_data when m_valid & m_ready
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
afull  out  1  count >= AFULL_THRESH
overrun  out  1  sticky: a byte was dropped because FIFO full
ferr  out  1  sticky: a byte arrived with rx_ferr=1
err_clr  in  1  clears overrun and ferr
drop_cnt  out  16  dropped-byte counter (see Optional Feature)

Behaviour:
- Reset (Rst_n=0 at rising Clk): wr_ptr=rd_ptr=0, count=0, m_valid=0, m_data=0, full=0, afull=0, overrun=0, ferr=0, drop_cnt=0. Reset has priority over every other input. Reset mid-stream discards all contents.
- Storage: DEPTH x DATA_W register array, log2(DEPTH)-bit pointers that wrap naturally. Occupancy is tracked by the count register, not by pointer compare.
- push_req = rx_valid & ~rx_ferr. pop = m_valid & m_ready.
- Push accepted = push_req & (~full | pop). When full, a simultaneous pop frees a slot and the push is accepted; count stays at DEPTH.
- Push rejected (push_req & full & ~pop): byte dropped, overrun<=1, pointers unchanged.
- rx_valid & rx_ferr: byte never written, ferr<=1, counts as a drop.
- count next = count + accepted_push - pop. Simultaneous push and pop on a non-full FIFO leaves count unchanged.
- Latency: a byte accepted at edge N is on m_data with m_valid=1 after edge N (visible in cycle N+1). This holds for an empty FIFO: FWFT, no extra cycle.
- m_data = mem[rd_ptr]. It is registered or read combinationally from registered storage; either way it is stable while m_valid & ~m_ready.
- Pop on empty is impossible because m_valid=0. m_ready is ignored when m_valid=0.
- full, afull and m_valid are derived from the registered count and are glitch-free.
- flush: pointers and count go to 0 next cycle. Any push or pop in the same cycle is ignored. overrun, ferr and drop_cnt are unaffected.
- err_clr: overrun<=0, ferr<=0. If a new error event occurs in the same cycle, the set wins (flag stays 1).
- The receiver guarantees at least 16*10 clocks between rx_valid strobes. The FIFO must nevertheless accept back-to-back strobes on consecutive cycles.

Optional Feature:
UART_RX_FIFO_STATS_EN
- Defined: drop_cnt is a 16-bit counter.
  - Increments by 1 per dropped byte (overrun drop or ferr byte).
  - Saturates at 0xFFFF.
  - Cleared by reset and by err_clr. If err_clr and a drop occur in the same cycle, the result is 1.
- Not defined: drop_cnt is tied to 16'h0000 and no counter logic is generated. The port remains present.

Test Plan:
1. Reset release, then a single rx_valid with rx_data=0x55 -> next cycle m_valid=1, m_data=0x55, count=1. Pulse m_ready for one cycle -> m_valid=0, count=0.
2. Push 0x00..0x0F back-to-back with m_ready=0 -> full=1, count=16; afull asserts when count reaches 12. Then drain with m_ready=1 -> output sequence 0x00..0x0F in order, empty after 16 pops.
3. Full FIFO, push 0xA5 with m_ready=0 -> overrun=1, count stays 16, 0xA5 never appears on output. Push 0x5A with m_ready=1 in the same cycle -> accepted, count=16, 0x5A is the last byte out.
4. rx_valid with rx_ferr=1 and data 0x33 -> ferr=1, count unchanged. Pulse err_clr -> ferr=0. With the macro defined, drop_cnt=1 before the clear and 0 after.
5. Fill with 5 bytes, then assert flush -> count=0, m_valid=0 next cycle, overrun unchanged. Assert Rst_n=0 for one cycle with 3 bytes held -> all outputs return to reset values.
6. Wrap-around: 40 interleaved push/pop operations with random m_ready -> output order and values match a reference queue, and count never exceeds 16.
